// File: rtl/clock_pkg.sv
// clock_pkg: shared definitions for the clock datapath BCD counters.
//   BCD_W / BCD_MAX : BCD digit width and largest legal digit value.
//   bcd_t / bcd2_t  : one BCD digit / a tens:ones digit pair.
//   digit_op_e      : per-digit operation selected by a counter's control logic.
//   bin2bcd()       : binary 0..99 to tens:ones, for elaboration-time constants.
package clock_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned BCD_MAX = 9;

  typedef logic [BCD_W-1:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_LOAD,
    OP_INC,
    OP_DEC
  } digit_op_e;

  function automatic bcd2_t bin2bcd(input int unsigned v);
    bcd2_t r;
    r.tens = bcd_t'(v / 10);
    r.ones = bcd_t'(v % 10);
    return r;
  endfunction

endpackage

// File: rtl/bcd_modn_counter_digit.sv
// bcd_digit: one BCD digit register.
//   clk  : rising-edge clock
//   clrn : asynchronous active-low reset (digit -> 0)
//   op_i : hold / clear / load d_i / increment / decrement
//   d_i  : value taken on OP_LOAD
//   q_o  : registered digit
// Increment past WRAP returns to 0; decrement below 0 returns to WRAP.
module bcd_digit
  import clock_pkg::*;
#(
  parameter int unsigned WRAP = BCD_MAX
) (
  input  logic      clk,
  input  logic      clrn,
  input  digit_op_e op_i,
  input  bcd_t      d_i,
  output bcd_t      q_o
);

  localparam bcd_t WRAP_B = bcd_t'(WRAP);

  bcd_t q_d, q_q;

  always_comb begin
    q_d = q_q;
    case (op_i)
      OP_CLR:  q_d = '0;
      OP_LOAD: q_d = d_i;
      OP_INC:  q_d = (q_q == WRAP_B) ? '0 : q_q + bcd_t'(1);
      OP_DEC:  q_d = (q_q == '0) ? WRAP_B : q_q - bcd_t'(1);
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/bcd_modn_counter.sv
// bcd_modn_counter: two-digit BCD up/down counter, modulo MOD (2..99).
//   clk             : rising-edge clock
//   clrn            : asynchronous active-low reset, count -> 00
//   sclr            : synchronous clear (highest priority)
//   load            : synchronous load of D_tens:D_ones if the value is legal
//   D_tens / D_ones : BCD value to load
//   en              : count enable (carry/borrow from the previous stage)
//   up              : 1 = count up, 0 = count down
//   Q_tens / Q_ones : registered count
//   Co / Bo         : combinational carry (at MOD-1, up) / borrow (at 00, down)
//   load_err        : registered one-cycle pulse after a rejected load
module bcd_modn_counter
  import clock_pkg::*;
#(
  parameter int unsigned MOD      = 60,
  parameter int unsigned ONES_MAX = BCD_MAX
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       sclr,
  input  logic       load,
  input  logic [3:0] D_tens,
  input  logic [3:0] D_ones,
  input  logic       en,
  input  logic       up,
  output logic [3:0] Q_tens,
  output logic [3:0] Q_ones,
  output logic       Co,
  output logic       Bo,
  output logic       load_err
);

  if (MOD < 2 || MOD > 99) begin : g_bad_mod
    $fatal(1, "bcd_modn_counter: MOD=%0d outside 2..99", MOD);
  end

  localparam bcd2_t      TOP        = bin2bcd(MOD - 1);
  localparam logic [7:0] MOD_B      = 8'(MOD);
  localparam bcd_t       ONES_MAX_B = bcd_t'(ONES_MAX);
  localparam bcd_t       BCD_MAX_B  = bcd_t'(BCD_MAX);

  logic       at_top, at_zero, ld_ok;
  logic [7:0] d_lin;
  digit_op_e  ones_op, tens_op;
  bcd_t       ones_ld, tens_ld;
  logic       load_err_d, load_err_q;

  // Exact-match decodes: a corrupted out-of-range count never raises Co/Bo.
  assign at_top  = (Q_tens == TOP.tens) && (Q_ones == TOP.ones);
  assign at_zero = (Q_tens == '0) && (Q_ones == '0);

  // Worst case 15*10+15 = 165 still fits in 8 bits.
  assign d_lin = 8'(D_tens) * 8'd10 + 8'(D_ones);
  assign ld_ok = (D_ones <= ONES_MAX_B) && (D_tens <= BCD_MAX_B) && (d_lin < MOD_B);

  // The MOD-1 wrap is done at this level: up-wrap clears both digits,
  // down-wrap reuses the digit load path to install MOD-1.
  always_comb begin
    ones_op    = OP_HOLD;
    tens_op    = OP_HOLD;
    ones_ld    = D_ones;
    tens_ld    = D_tens;
    load_err_d = 1'b0;
    if (sclr) begin
      ones_op = OP_CLR;
      tens_op = OP_CLR;
    end else if (load) begin
      if (ld_ok) begin
        ones_op = OP_LOAD;
        tens_op = OP_LOAD;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (en) begin
      if (up) begin
        if (at_top) begin
          ones_op = OP_CLR;
          tens_op = OP_CLR;
        end else begin
          ones_op = OP_INC;
          if (Q_ones == ONES_MAX_B) tens_op = OP_INC;
        end
      end else begin
        if (at_zero) begin
          ones_op = OP_LOAD;
          tens_op = OP_LOAD;
          ones_ld = TOP.ones;
          tens_ld = TOP.tens;
        end else begin
          ones_op = OP_DEC;
          if (Q_ones == '0) tens_op = OP_DEC;
        end
      end
    end
  end

  bcd_digit #(.WRAP(ONES_MAX)) u_ones (
    .clk  (clk),
    .clrn (clrn),
    .op_i (ones_op),
    .d_i  (ones_ld),
    .q_o  (Q_ones)
  );

  bcd_digit #(.WRAP(BCD_MAX)) u_tens (
    .clk  (clk),
    .clrn (clrn),
    .op_i (tens_op),
    .d_i  (tens_ld),
    .q_o  (Q_tens)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) load_err_q <= 1'b0;
    else       load_err_q <= load_err_d;
  end

  assign load_err = load_err_q;
  assign Co       = en && up && at_top;
  assign Bo       = en && !up && at_zero;

endmodule

// File: doc/bcd_modn_counter.md
# bcd_modn_counter

Parametrised two-digit BCD modulo-N counter for the clock datapath. It generalises the single-digit mod-6 stage into one block that serves as seconds/minutes (MOD=60), hours (MOD=24 or 12) or any modulus from 2 to 99. It counts up or down with synchronous load and clear, validates loaded values, and drives combinational carry/borrow outputs so stages chain on the same clock edge.

## Interface
- MOD, 60, counting modulus; legal range 2..99; count runs 0..MOD-1.
- ONES_MAX, 9, ones-digit wrap value; fixed BCD, not overridden.
- clk  in  1  rising-edge clock.
- clrn  in  1  reset, asynchronous, active-low; forces count to 00.
- sclr  in  1  synchronous clear to 00.
- load  in  1  synchronous load of D_tens:D_ones.
- D_tens  in  4  BCD tens digit to load.
- D_ones  in  4  BCD ones digit to load.
- en  in  1  count enable; the carry/borrow input from the previous stage.
- up  in  1  direction: 1 = increment, 0 = decrement.
- Q_tens  out  4  registered tens digit.
- Q_ones  out  4  registered ones digit.
- Co  out  1  carry: count is MOD-1 and en and up; combinational.
- Bo  out  1  borrow: count is 00 and en and not up; combinational.
- load_err  out  1  registered one-cycle pulse when a load is rejected.

## Operation
- Priority on each rising clk edge: sclr, then load, then en. clrn overrides all of them asynchronously.
- sclr=1: Q becomes 00. load_err becomes 0.
- load=1 with a valid value: Q becomes D.
  - A value is valid when D_ones ≤ 9, D_tens ≤ 9, and 10·D_tens + D_ones < MOD.
- load=1 with an invalid value: Q holds and load_err is 1 for that cycle. The enable is not applied that cycle either.
- en=1, up=1:
  - ones < 9 and count ≠ MOD-1: ones increments.
  - ones = 9: ones goes to 0 and tens increments.
  - count = MOD-1: Q becomes 00. This is the wrap point and overrides the ones rule; for example MOD=24 wraps at 23.
- en=1, up=0:
  - ones > 0: ones decrements.
  - ones = 0 and tens > 0: ones goes to 9 and tens decrements.
  - count = 00: Q becomes MOD-1 in BCD.
- en=0, with no load or sclr: Q holds.
- load_err is 0 in every cycle without a rejected load.
- Co and Bo are never both 1.
- An out-of-range Q can only result from an implementation fault. The block does not correct it, but Co/Bo must not assert for it, and the bench flags it.

## Timing
- Reset values: Q_tens=0, Q_ones=0, load_err=0. Co=0 and Bo=0 follow because Q=00 and up/en decode accordingly.
  - Exception: Bo=1 during reset if en=1 and up=0, since Bo is combinational.
- Q updates one cycle after the qualifying edge. load_err is valid the cycle after the rejected load.
- Co and Bo have zero latency. A downstream stage whose en is driven by Co/Bo advances on the same edge as the wrapping stage.
- clrn asserted mid-count clears Q immediately, without waiting for a clock. Deassertion is synchronised externally; the block assumes clean release relative to clk.
- Simultaneous sclr and load: clear wins and load_err stays 0.
- Simultaneous load and en: load wins and no count step occurs.
- A direction change takes effect on the next enabled edge. Co/Bo switch combinationally with up.

## Structure
- Shared package clock_pkg holds:
  - BCD digit width (4) and BCD_MAX (9).
  - A function or macro converting a binary 0..99 value to a tens/ones pair, used to derive MOD-1 tens/ones constants at elaboration.
- Elaboration check: MOD outside 2..99 is a fatal error.
- One sub-module, bcd_digit:
  - 4-bit register with inc/dec/load/clear and a configurable wrap value.
  - Instantiated twice. The top level computes the MOD-1 wrap override and the load validity check.

## Test plan
- Reset and count, MOD=60, up=1, en=1: pulse clrn low mid-count at 37 → Q=00 immediately. Run 60 cycles → Q returns to 00. Co=1 only while Q=59.
- Hours wrap, MOD=24: load 22, then count up 2 cycles → 23, then 00. Co is high in the cycle Q=23.
- Down count, MOD=60, up=0 from 10 → 09, 08, … 00, then 59. Bo=1 only while Q=00.
- Invalid loads, MOD=60: load 6:0 → Q unchanged and load_err=1 for 1 cycle. Load 1:A → rejected. Load 5:9 → accepted.
- Priority: sclr+load+en in one cycle → Q=00 and load_err=0. load+en with value 42 → Q=42, with no increment.
- Cascade: seconds MOD=60 Co drives minutes MOD=60 en. From 59:59 → 00:00 on one edge, with the minutes Co asserted during 59:59.
